spart_tx_arb: RTL and testbench

SPART_TX_ARB -- requirements
Module: spart_tx_arb

---
 rtl/spart_pkg.sv | 6 +
 rtl/spart_rr_arb.sv | 24 ++
 rtl/spart_tx_arb.sv | 85 ++++++++
 tb/tb_spart_tx_arb.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/spart_pkg.sv
// spart_pkg: shared FSM state type, reset divisor and requester count for the SPART transmit arbiter.
package spart_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_t;
    localparam logic [15:0] DEFAULT_DIV = 16'd325;
    localparam int NUM_REQ = 2;
endpackage

// File: rtl/spart_rr_arb.sv
// spart_rr_arb: two-way round-robin arbiter holding the last-winner flop.
// SPART_ARB_FIXED_PRIO_EN turns it into fixed priority with requester 0 first.
module spart_rr_arb
    import spart_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               adv,
    output logic [NUM_REQ-1:0] grant
);
`ifdef SPART_ARB_FIXED_PRIO_EN
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rst, adv};
    always_comb grant = req[0] ? 2'b01 : {req[1], 1'b0};
`else
    logic last;
    always_ff @(posedge clk or posedge rst)
        if (rst) last <= 1'b1;
        else if (adv) last <= grant[1];
    // on a tie the requester that did not win last time goes next
    always_comb grant = &req ? (last ? 2'b01 : 2'b10) : req;
`endif
endmodule

// File: rtl/spart_tx_arb.sv
// spart_tx_arb: arbitrates two byte requesters onto one SPART transmitter and stages the baud divisor.
// Arbitration mode selected by SPART_ARB_FIXED_PRIO_EN (see spart_rr_arb).
module spart_tx_arb #(
    parameter logic [15:0] DEFAULT_DIV  = spart_pkg::DEFAULT_DIV,
    parameter logic [7:0]  BUSY_TIMEOUT = 8'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [7:0]  req_data0,
    input  logic [7:0]  req_data1,
    output logic [1:0]  ack,
    input  logic        cfg_we,
    input  logic        cfg_hi,
    input  logic [7:0]  cfg_data,
    input  logic        tbr,
    output logic        tx_begin,
    output logic [7:0]  transmit_buffer,
    output logic [15:0] divisor_buffer,
    output logic        busy,
    output logic        timeout_err
);
    import spart_pkg::*;

    state_t      state, state_nxt;
    logic [1:0]  grant;
    logic [7:0]  cnt;
    logic [15:0] stg;
    logic        pending, fire, to, commit;

    spart_rr_arb u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .adv   (fire),
        .grant (grant)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      state_nxt = fire ? LOAD : IDLE;
            LOAD:      state_nxt = WAIT_BUSY;
            WAIT_BUSY: state_nxt = !tbr ? WAIT_DONE : (to ? IDLE : WAIT_BUSY);
            WAIT_DONE: state_nxt = tbr ? IDLE : WAIT_DONE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        fire   = (state == IDLE) && tbr && |grant;
        to     = (state == WAIT_BUSY) && tbr && (cnt == BUSY_TIMEOUT - 8'd1);
        commit = (state == IDLE) && pending;
        busy   = state != IDLE;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            ack             <= '0;
            tx_begin        <= 1'b0;
            transmit_buffer <= 8'hFF;
            divisor_buffer  <= DEFAULT_DIV;
            stg             <= DEFAULT_DIV;
            pending         <= 1'b0;
            cnt             <= '0;
            timeout_err     <= 1'b0;
        end else begin
            ack      <= fire ? grant : 2'b00;
            tx_begin <= state == LOAD;
            cnt      <= (state == WAIT_BUSY) ? cnt + 8'd1 : 8'd0;
            if (fire) transmit_buffer <= grant[1] ? req_data1 : req_data0;
            if (to) timeout_err <= 1'b1;
            // an all-zero divisor would stall the baud generator, so it is dropped
            if (commit && stg != 16'h0000) divisor_buffer <= stg;
            if (cfg_we) begin
                if (cfg_hi) stg[15:8] <= cfg_data;
                else stg[7:0] <= cfg_data;
                pending <= 1'b1;
            end else if (commit) pending <= 1'b0;
        end
endmodule

// File: tb/tb_spart_tx_arb.sv
module tb_spart_tx_arb;
    logic        clk = 0;
    logic        rst = 0;
    logic [1:0]  req = 0;
    logic [7:0]  req_data0 = 0, req_data1 = 0;
    logic [1:0]  ack;
    logic        cfg_we = 0, cfg_hi = 0;
    logic [7:0]  cfg_data = 0;
    logic        tbr = 1;
    logic        tx_begin;
    logic [7:0]  transmit_buffer;
    logic [15:0] divisor_buffer;
    logic        busy, timeout_err;
    int tests = 0, fails = 0;

    spart_tx_arb dut (
        .clk(clk), .rst(rst), .req(req), .req_data0(req_data0), .req_data1(req_data1),
        .ack(ack), .cfg_we(cfg_we), .cfg_hi(cfg_hi), .cfg_data(cfg_data), .tbr(tbr),
        .tx_begin(tx_begin), .transmit_buffer(transmit_buffer),
        .divisor_buffer(divisor_buffer), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1;
        tick();
        tick();
        rst = 0;
        tests++; if (ack !== 2'b00) begin fails++; $display("FAIL reset_ack: got %b want 00", ack); end
        tests++; if (tx_begin !== 1'b0) begin fails++; $display("FAIL reset_tx_begin: got %b want 0", tx_begin); end
        tests++; if (transmit_buffer !== 8'hFF) begin fails++; $display("FAIL reset_tbuf: got %h want ff", transmit_buffer); end
        tests++; if (divisor_buffer !== 16'd325) begin fails++; $display("FAIL reset_div: got %0d want 325", divisor_buffer); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL reset_timeout: got %b want 0", timeout_err); end
    endtask

    task automatic test_single();
        tbr = 1; req = 2'b01; req_data0 = 8'hA5; req_data1 = 8'h3C;
        tick();
        tests++; if (ack !== 2'b01) begin fails++; $display("FAIL single_ack: got %b want 01", ack); end
        tests++; if (tx_begin !== 1'b0) begin fails++; $display("FAIL single_early_tx: got %b want 0", tx_begin); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy: got %b want 1", busy); end
        req = 2'b00;
        tick();
        tests++; if (tx_begin !== 1'b1) begin fails++; $display("FAIL single_tx_begin: got %b want 1", tx_begin); end
        tests++; if (ack !== 2'b00) begin fails++; $display("FAIL single_ack_pulse: got %b want 00", ack); end
        tests++; if (transmit_buffer !== 8'hA5) begin fails++; $display("FAIL single_tbuf: got %h want a5", transmit_buffer); end
        tbr = 0;
        tick();
        tests++; if (tx_begin !== 1'b0) begin fails++; $display("FAIL single_tx_once: got %b want 0", tx_begin); end
        tick();
        tbr = 1;
        tick();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_idle: got %b want 0", busy); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_ack [3];
        logic [7:0] exp_buf [3];
        exp_ack[0] = 2'b01; exp_ack[1] = 2'b10; exp_ack[2] = 2'b01;
        exp_buf[0] = 8'h11; exp_buf[1] = 8'h22; exp_buf[2] = 8'h11;
        test_reset();
        req_data0 = 8'h11; req_data1 = 8'h22; tbr = 1; req = 2'b11;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (ack !== exp_ack[i]) begin fails++; $display("FAIL rr_ack%0d: got %b want %b", i, ack, exp_ack[i]); end
            tests++; if (transmit_buffer !== exp_buf[i]) begin fails++; $display("FAIL rr_tbuf%0d: got %h want %h", i, transmit_buffer, exp_buf[i]); end
            tick();
            tbr = 0;
            repeat (3) tick();
            tbr = 1;
            tick();
            tests++; if (ack !== 2'b00) begin fails++; $display("FAIL rr_no_regrant%0d: got %b want 00", i, ack); end
        end
        req = 2'b00;
        tick();
    endtask

    task automatic test_divisor();
        tbr = 1; req = 2'b01;
        tick();
        req = 2'b00;
        tick();
        tbr = 0;
        tick();
        cfg_we = 1; cfg_hi = 0; cfg_data = 8'h10;
        tick();
        cfg_hi = 1; cfg_data = 8'h00;
        tick();
        cfg_we = 0;
        tick();
        tests++; if (divisor_buffer !== 16'd325) begin fails++; $display("FAIL div_hold_frame: got %h want 0145", divisor_buffer); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL div_in_frame: got %b want 1", busy); end
        tbr = 1;
        tick();
        tests++; if (divisor_buffer !== 16'd325) begin fails++; $display("FAIL div_hold_entry: got %h want 0145", divisor_buffer); end
        tick();
        tests++; if (divisor_buffer !== 16'h0010) begin fails++; $display("FAIL div_commit: got %h want 0010", divisor_buffer); end
        tests++; if (dut.pending !== 1'b0) begin fails++; $display("FAIL div_pending_clr: got %b want 0", dut.pending); end
    endtask

    task automatic test_zero_divisor();
        cfg_we = 1; cfg_hi = 0; cfg_data = 8'h00;
        tick();
        cfg_we = 0;
        tests++; if (dut.pending !== 1'b1) begin fails++; $display("FAIL zero_pending_set: got %b want 1", dut.pending); end
        tick();
        tests++; if (divisor_buffer !== 16'h0010) begin fails++; $display("FAIL zero_div_kept: got %h want 0010", divisor_buffer); end
        tests++; if (dut.pending !== 1'b0) begin fails++; $display("FAIL zero_pending_clr: got %b want 0", dut.pending); end
    endtask

    task automatic test_commit_with_grant();
        cfg_we = 1; cfg_hi = 0; cfg_data = 8'h20;
        tick();
        cfg_we = 0; req = 2'b01; req_data0 = 8'h5A;
        tick();
        tests++; if (divisor_buffer !== 16'h0020) begin fails++; $display("FAIL cg_div: got %h want 0020", divisor_buffer); end
        tests++; if (ack !== 2'b01) begin fails++; $display("FAIL cg_ack: got %b want 01", ack); end
        req = 2'b00;
        tick();
        tests++; if (transmit_buffer !== 8'h5A) begin fails++; $display("FAIL cg_tbuf: got %h want 5a", transmit_buffer); end
        tbr = 0;
        tick();
        tbr = 1;
        tick();
    endtask

    task automatic test_drop();
        tbr = 0; req = 2'b10;
        tick();
        tick();
        tests++; if (ack !== 2'b00) begin fails++; $display("FAIL drop_ack_wait: got %b want 00", ack); end
        req = 2'b00; tbr = 1;
        tick();
        tick();
        tests++; if (ack !== 2'b00) begin fails++; $display("FAIL drop_ack: got %b want 00", ack); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL drop_busy: got %b want 0", busy); end
    endtask

    task automatic test_timeout();
        tbr = 1; req = 2'b10; req_data1 = 8'hC3;
        tick();
        tests++; if (ack !== 2'b10) begin fails++; $display("FAIL to_ack: got %b want 10", ack); end
        req = 2'b00;
        tick();
        tests++; if (tx_begin !== 1'b1) begin fails++; $display("FAIL to_tx_begin: got %b want 1", tx_begin); end
        repeat (3) tick();
        tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL to_early: got %b want 0", timeout_err); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL to_still_busy: got %b want 1", busy); end
        tick();
        tests++; if (timeout_err !== 1'b1) begin fails++; $display("FAIL to_flag: got %b want 1", timeout_err); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL to_idle: got %b want 0", busy); end
        repeat (2) tick();
        tests++; if (timeout_err !== 1'b1) begin fails++; $display("FAIL to_sticky: got %b want 1", timeout_err); end
        tests++; if (ack !== 2'b00 || tx_begin !== 1'b0) begin fails++; $display("FAIL to_no_retry: got ack %b tx %b want 00 0", ack, tx_begin); end
    endtask

    task automatic test_reset_mid_frame();
        tbr = 1; req = 2'b01;
        tick();
        req = 2'b00;
        tick();
        tbr = 0;
        tick();
        #2;
        rst = 1;
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rmid_busy: got %b want 0", busy); end
        tests++; if (transmit_buffer !== 8'hFF) begin fails++; $display("FAIL rmid_tbuf: got %h want ff", transmit_buffer); end
        tests++; if (divisor_buffer !== 16'd325) begin fails++; $display("FAIL rmid_div: got %h want 0145", divisor_buffer); end
        tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL rmid_timeout: got %b want 0", timeout_err); end
        tests++; if (ack !== 2'b00 || tx_begin !== 1'b0) begin fails++; $display("FAIL rmid_pulses: got ack %b tx %b want 00 0", ack, tx_begin); end
        tick();
        rst = 0; tbr = 1;
        repeat (3) tick();
        tests++; if (ack !== 2'b00 || tx_begin !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL rmid_no_retry: got ack %b tx %b busy %b want 00 0 0", ack, tx_begin, busy); end
    endtask

    initial begin
        #2;
        test_reset();
        test_single();
        test_round_robin();
        test_divisor();
        test_zero_divisor();
        test_commit_with_grant();
        test_drop();
        test_timeout();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
